// File: rtl/mux_scan_serializer_pkg.sv
// Shared definitions for the mux scan serializer: state encoding, channel
// count, select width and settle-counter width.
package mux_scan_serializer_pkg;

  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

  // First channel visited by a scan.
  function automatic logic [SEL_W-1:0] start_ch(input int msb_first);
    return (msb_first != 0) ? SEL_W'(NUM_CH - 1) : '0;
  endfunction

  // Channel that terminates a scan.
  function automatic logic [SEL_W-1:0] end_ch(input int msb_first);
    return (msb_first != 0) ? '0 : SEL_W'(NUM_CH - 1);
  endfunction

endpackage

// File: rtl/eight_one.sv
// 8:1 multiplexer exercised by the scan serializer.
// Ports:
//   i_i   [7:0]  data inputs
//   sel_i [2:0]  channel select
//   y_o          selected data bit
module eight_one (
  input  logic [7:0] i_i,
  input  logic [2:0] sel_i,
  output logic       y_o
);

  assign y_o = i_i[sel_i];

endmodule

// File: rtl/mux_scan_serializer_seq.sv
// Scan sequencer: state register, settle counter and select stepper.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   load_i         a word is accepted this cycle (only meaningful in IDLE)
//   abort_i        abandon the current scan (ignored in IDLE)
//   bit_hs_i       serial bit handshake this cycle
//   state_o        current state
//   state_d_o      next state (used by the top to register in_ready)
//   sel_o          current mux select
//   last_o         current select is the terminating channel
module mux_scan_seq
  import mux_scan_serializer_pkg::*;
#(
  parameter int MSB_FIRST = 0,
  parameter int SETTLE    = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             abort_i,
  input  logic             bit_hs_i,
  output state_e           state_o,
  output state_e           state_d_o,
  output logic [SEL_W-1:0] sel_o,
  output logic             last_o
);

  localparam logic [CNT_W-1:0] SETTLE_CNT = CNT_W'(SETTLE);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [SEL_W-1:0] SEL_ONE    = SEL_W'(1);
  localparam logic [SEL_W-1:0] START_CH   = start_ch(MSB_FIRST);
  localparam logic [SEL_W-1:0] END_CH     = end_ch(MSB_FIRST);
  // With no settle time a select change goes straight to the sample cycle.
  localparam state_e           AFTER_SEL  = (SETTLE > 0) ? ST_SETTLE : ST_SAMPLE;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;

  assign last_o = (sel_q == END_CH);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    case (state_q)
      ST_IDLE: begin
        if (load_i) begin
          sel_d   = START_CH;
          cnt_d   = SETTLE_CNT;
          state_d = AFTER_SEL;
        end
      end
      ST_SETTLE: begin
        if (abort_i) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
          // <= guards against a zero count ever stalling here.
          if (cnt_q <= CNT_ONE) state_d = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        state_d = abort_i ? ST_IDLE : ST_HOLD;
      end
      ST_HOLD: begin
        if (abort_i) begin
          state_d = ST_IDLE;
        end else if (bit_hs_i) begin
          if (last_o) begin
            state_d = ST_IDLE;
          end else begin
            sel_d   = (MSB_FIRST != 0) ? (sel_q - SEL_ONE) : (sel_q + SEL_ONE);
            cnt_d   = SETTLE_CNT;
            state_d = AFTER_SEL;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
    end
  end

  assign state_o   = state_q;
  assign state_d_o = state_d;
  assign sel_o     = sel_q;

endmodule

// File: rtl/mux_scan_serializer.sv
// Drives an 8:1 mux with a held word, steps its select through all eight
// channels, samples the mux output after a settle time and streams one bit
// per channel. Each sample is compared with the held word; any disagreement
// sets a sticky error flag, giving an in-system self-check of the mux.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready/in_data  8-bit word input handshake
//   abort                      abandon the current scan
//   mux_i, mux_sel, mux_y      connection to the mux (data, select, output)
//   bit_valid/bit_ready        serial bit handshake
//   bit_out, bit_last, bit_idx sampled value, end-of-word marker, channel
//   err                        sticky mismatch flag, cleared on load
module mux_scan_serializer
  import mux_scan_serializer_pkg::*;
#(
  parameter int MSB_FIRST = 0,
  parameter int SETTLE    = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             abort,
  output logic [7:0]       mux_i,
  output logic [SEL_W-1:0] mux_sel,
  input  logic             mux_y,
  output logic             bit_valid,
  input  logic             bit_ready,
  output logic             bit_out,
  output logic             bit_last,
  output logic [SEL_W-1:0] bit_idx,
  output logic             err
);

  state_e           state, state_nxt;
  logic [SEL_W-1:0] sel;
  logic             last_ch;
  logic             load, bit_hs;

  logic             in_ready_q, in_ready_d;
  logic [7:0]       mux_i_q, mux_i_d;
  logic             bit_valid_q, bit_valid_d;
  logic             bit_out_q, bit_out_d;
  logic             bit_last_q, bit_last_d;
  logic [SEL_W-1:0] bit_idx_q, bit_idx_d;
  logic             err_q, err_d;

  assign load   = in_valid && in_ready_q;
  assign bit_hs = bit_valid_q && bit_ready;

  mux_scan_seq #(
    .MSB_FIRST (MSB_FIRST),
    .SETTLE    (SETTLE)
  ) u_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (load),
    .abort_i   (abort),
    .bit_hs_i  (bit_hs),
    .state_o   (state),
    .state_d_o (state_nxt),
    .sel_o     (sel),
    .last_o    (last_ch)
  );

  always_comb begin
    mux_i_d     = mux_i_q;
    err_d       = err_q;
    bit_valid_d = bit_valid_q;
    bit_out_d   = bit_out_q;
    bit_last_d  = bit_last_q;
    bit_idx_d   = bit_idx_q;
    // Registered ready tracks the sequencer's next state, so it is high
    // exactly while the sequencer sits in IDLE (and low during reset).
    in_ready_d  = (state_nxt == ST_IDLE);
    case (state)
      ST_IDLE: begin
        if (load) begin
          mux_i_d = in_data;
          err_d   = 1'b0;
        end
      end
      ST_SAMPLE: begin
        if (abort) begin
          bit_valid_d = 1'b0;
          bit_last_d  = 1'b0;
        end else begin
          bit_out_d   = mux_y;
          bit_idx_d   = sel;
          bit_last_d  = last_ch;
          bit_valid_d = 1'b1;
          if (mux_y != mux_i_q[sel]) err_d = 1'b1;
        end
      end
      ST_SETTLE, ST_HOLD: begin
        // Abort wins over a simultaneous handshake; either way the bit is done.
        if (abort) begin
          bit_valid_d = 1'b0;
          bit_last_d  = 1'b0;
        end else if (bit_hs) begin
          bit_valid_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_q  <= 1'b0;
      mux_i_q     <= '0;
      bit_valid_q <= 1'b0;
      bit_out_q   <= 1'b0;
      bit_last_q  <= 1'b0;
      bit_idx_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      in_ready_q  <= in_ready_d;
      mux_i_q     <= mux_i_d;
      bit_valid_q <= bit_valid_d;
      bit_out_q   <= bit_out_d;
      bit_last_q  <= bit_last_d;
      bit_idx_q   <= bit_idx_d;
      err_q       <= err_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign mux_i     = mux_i_q;
  assign mux_sel   = sel;
  assign bit_valid = bit_valid_q;
  assign bit_out   = bit_out_q;
  assign bit_last  = bit_last_q;
  assign bit_idx   = bit_idx_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mux_scan_serializer.sv
// Bench for mux_scan_serializer. Three instances share clock and reset:
//   0: MSB_FIRST=0, SETTLE=1 (with a stuck-at-0 fault hook on its mux output)
//   1: MSB_FIRST=1, SETTLE=1
//   2: MSB_FIRST=0, SETTLE=0
// Each sits on top of its own eight_one mux.
module tb_mux_scan_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic [2:0]      in_valid, abort, bit_ready;
  logic [2:0][7:0] in_data;
  logic            fault;

  wire  [2:0]      in_ready, bit_valid, bit_out, bit_last, err, mux_y, y_raw;
  wire  [2:0][7:0] mux_i;
  wire  [2:0][2:0] mux_sel, bit_idx;

  int checks = 0;
  int errors = 0;

  generate
    for (genvar g = 0; g < 3; g++) begin : g_dut
      eight_one u_mux (
        .i_i   (mux_i[g]),
        .sel_i (mux_sel[g]),
        .y_o   (y_raw[g])
      );

      assign mux_y[g] = (g == 0 && fault) ? 1'b0 : y_raw[g];

      mux_scan_serializer #(
        .MSB_FIRST ((g == 1) ? 1 : 0),
        .SETTLE    ((g == 2) ? 0 : 1)
      ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid[g]),
        .in_ready  (in_ready[g]),
        .in_data   (in_data[g]),
        .abort     (abort[g]),
        .mux_i     (mux_i[g]),
        .mux_sel   (mux_sel[g]),
        .mux_y     (mux_y[g]),
        .bit_valid (bit_valid[g]),
        .bit_ready (bit_ready[g]),
        .bit_out   (bit_out[g]),
        .bit_last  (bit_last[g]),
        .bit_idx   (bit_idx[g]),
        .err       (err[g])
      );
    end
  endgenerate

  // Called at a negedge; offers the word across exactly one rising edge.
  task automatic load(input int k, input logic [7:0] w);
    in_data[k]  = w;
    in_valid[k] = 1'b1;
    @(negedge clk);
    in_valid[k] = 1'b0;
  endtask

  // Counts rising edges until bit_valid is seen, bounded at 40.
  task automatic wait_valid(input int k, output int cyc);
    cyc = 0;
    while (bit_valid[k] !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst_n     = 1'b0;
    fault     = 1'b0;
    in_valid  = '0;
    abort     = '0;
    bit_ready = '0;
    in_data   = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (in_ready !== 3'b000 || bit_valid !== 3'b000 || err !== 3'b000 ||
        bit_out !== 3'b000 || bit_last !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags rdy=%b vld=%b err=%b out=%b last=%b exp all 0",
               in_ready, bit_valid, err, bit_out, bit_last);
    end
    checks++;
    if (mux_i[0] !== 8'h00 || mux_sel[0] !== 3'd0 || bit_idx[0] !== 3'd0) begin
      errors++;
      $display("FAIL reset_regs mux_i=%h sel=%0d idx=%0d exp 0", mux_i[0], mux_sel[0], bit_idx[0]);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 3'b111) begin
      errors++;
      $display("FAIL reset_release_ready got=%b exp=111", in_ready);
    end
  endtask

  task automatic test_lsb_first;
    logic [7:0] w;
    int cyc;
    w = 8'hA5;
    bit_ready[0] = 1'b1;
    load(0, w);
    checks++;
    if (in_ready[0] !== 1'b0 || mux_i[0] !== w || mux_sel[0] !== 3'd0) begin
      errors++;
      $display("FAIL t1_load rdy=%b mux_i=%h sel=%0d exp 0/a5/0", in_ready[0], mux_i[0], mux_sel[0]);
    end
    for (int i = 0; i < 8; i++) begin
      wait_valid(0, cyc);
      checks++;
      if (cyc != 2) begin
        errors++;
        $display("FAIL t1_latency bit=%0d got=%0d exp=2", i, cyc);
      end
      checks++;
      if (bit_out[0] !== w[i] || bit_idx[0] !== 3'(i) || bit_last[0] !== (i == 7) || err[0] !== 1'b0) begin
        errors++;
        $display("FAIL t1_bit i=%0d out=%b idx=%0d last=%b err=%b exp out=%b idx=%0d last=%b err=0",
                 i, bit_out[0], bit_idx[0], bit_last[0], err[0], w[i], i, (i == 7));
      end
      @(negedge clk);
    end
    checks++;
    if (in_ready[0] !== 1'b1 || bit_valid[0] !== 1'b0) begin
      errors++;
      $display("FAIL t1_end rdy=%b vld=%b exp 1/0", in_ready[0], bit_valid[0]);
    end
  endtask

  task automatic test_msb_first;
    logic [7:0] w;
    int cyc;
    w = 8'h3C;
    bit_ready[1] = 1'b1;
    load(1, w);
    checks++;
    if (mux_sel[1] !== 3'd7) begin
      errors++;
      $display("FAIL t2_start_sel got=%0d exp=7", mux_sel[1]);
    end
    for (int i = 0; i < 8; i++) begin
      wait_valid(1, cyc);
      checks++;
      if (bit_valid[1] !== 1'b1 || bit_out[1] !== w[7-i] || bit_idx[1] !== 3'(7 - i) ||
          bit_last[1] !== (i == 7) || err[1] !== 1'b0) begin
        errors++;
        $display("FAIL t2_bit i=%0d vld=%b out=%b idx=%0d last=%b err=%b exp out=%b idx=%0d last=%b",
                 i, bit_valid[1], bit_out[1], bit_idx[1], bit_last[1], err[1], w[7-i], 7 - i, (i == 7));
      end
      @(negedge clk);
    end
    checks++;
    if (in_ready[1] !== 1'b1) begin
      errors++;
      $display("FAIL t2_end_ready got=%b exp=1", in_ready[1]);
    end
  endtask

  task automatic test_stall;
    int cyc;
    bit_ready[0] = 1'b1;
    load(0, 8'hFF);
    for (int i = 0; i < 8; i++) begin
      wait_valid(0, cyc);
      checks++;
      if (bit_valid[0] !== 1'b1 || bit_out[0] !== 1'b1 || bit_idx[0] !== 3'(i) || bit_last[0] !== (i == 7)) begin
        errors++;
        $display("FAIL t3_bit i=%0d vld=%b out=%b idx=%0d last=%b exp 1/1/%0d/%b",
                 i, bit_valid[0], bit_out[0], bit_idx[0], bit_last[0], i, (i == 7));
      end
      if (i == 3) begin
        bit_ready[0] = 1'b0;
        // A word offered mid-scan must be ignored.
        in_data[0]   = 8'h00;
        in_valid[0]  = 1'b1;
        repeat (5) begin
          @(negedge clk);
          checks++;
          if (bit_valid[0] !== 1'b1 || bit_out[0] !== 1'b1 || bit_idx[0] !== 3'd3 ||
              mux_sel[0] !== 3'd3 || mux_i[0] !== 8'hFF) begin
            errors++;
            $display("FAIL t3_stall vld=%b out=%b idx=%0d sel=%0d mux_i=%h exp 1/1/3/3/ff",
                     bit_valid[0], bit_out[0], bit_idx[0], mux_sel[0], mux_i[0]);
          end
        end
        in_valid[0]  = 1'b0;
        bit_ready[0] = 1'b1;
      end
      @(negedge clk);
    end
    checks++;
    if (in_ready[0] !== 1'b1 || mux_i[0] !== 8'hFF) begin
      errors++;
      $display("FAIL t3_end rdy=%b mux_i=%h exp 1/ff", in_ready[0], mux_i[0]);
    end
  endtask

  task automatic test_fault;
    logic [7:0] w;
    int cyc;
    bit_ready[0] = 1'b1;
    fault = 1'b1;
    load(0, 8'h80);
    for (int i = 0; i < 8; i++) begin
      wait_valid(0, cyc);
      checks++;
      if (bit_valid[0] !== 1'b1 || bit_out[0] !== 1'b0 || bit_idx[0] !== 3'(i) || err[0] !== (i == 7)) begin
        errors++;
        $display("FAIL t4_bit i=%0d vld=%b out=%b idx=%0d err=%b exp 1/0/%0d/%b",
                 i, bit_valid[0], bit_out[0], bit_idx[0], err[0], i, (i == 7));
      end
      @(negedge clk);
    end
    fault = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (err[0] !== 1'b1 || in_ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL t4_sticky err=%b rdy=%b exp 1/1", err[0], in_ready[0]);
    end
    w = 8'h0F;
    load(0, w);
    checks++;
    if (err[0] !== 1'b0) begin
      errors++;
      $display("FAIL t4_clear_on_load err=%b exp=0", err[0]);
    end
    for (int i = 0; i < 8; i++) begin
      wait_valid(0, cyc);
      checks++;
      if (bit_valid[0] !== 1'b1 || bit_out[0] !== w[i] || err[0] !== 1'b0) begin
        errors++;
        $display("FAIL t4_clean i=%0d vld=%b out=%b err=%b exp 1/%b/0", i, bit_valid[0], bit_out[0], err[0], w[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_abort;
    logic [7:0] w;
    int cyc;
    bit seen;
    bit_ready[0] = 1'b1;
    load(0, 8'hC3);
    for (int i = 0; i < 4; i++) begin
      wait_valid(0, cyc);
      @(negedge clk);
    end
    // Now in the settle cycle of channel 4.
    checks++;
    if (mux_sel[0] !== 3'd4 || bit_valid[0] !== 1'b0) begin
      errors++;
      $display("FAIL t5_pre_abort sel=%0d vld=%b exp 4/0", mux_sel[0], bit_valid[0]);
    end
    abort[0] = 1'b1;
    @(negedge clk);
    abort[0] = 1'b0;
    checks++;
    if (in_ready[0] !== 1'b1 || bit_valid[0] !== 1'b0 || bit_last[0] !== 1'b0 ||
        mux_sel[0] !== 3'd4 || mux_i[0] !== 8'hC3 || err[0] !== 1'b0) begin
      errors++;
      $display("FAIL t5_abort rdy=%b vld=%b last=%b sel=%0d mux_i=%h err=%b exp 1/0/0/4/c3/0",
               in_ready[0], bit_valid[0], bit_last[0], mux_sel[0], mux_i[0], err[0]);
    end
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bit_valid[0] === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL t5_no_more_bits got bit_valid=1 exp no bits after abort");
    end
    w = 8'h01;
    load(0, w);
    for (int i = 0; i < 8; i++) begin
      wait_valid(0, cyc);
      checks++;
      if (bit_valid[0] !== 1'b1 || bit_out[0] !== w[i] || bit_idx[0] !== 3'(i) || err[0] !== 1'b0 ||
          (i == 0 && cyc != 2)) begin
        errors++;
        $display("FAIL t5_rescan i=%0d vld=%b out=%b idx=%0d err=%b cyc=%0d exp 1/%b/%0d/0",
                 i, bit_valid[0], bit_out[0], bit_idx[0], err[0], cyc, w[i], i);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_scan;
    logic [7:0] w;
    int cyc;
    bit seen;
    bit_ready[0] = 1'b1;
    load(0, 8'h5A);
    for (int i = 0; i < 3; i++) begin
      wait_valid(0, cyc);
      if (i < 2) @(negedge clk);
    end
    // Holding channel 2.
    bit_ready[0] = 1'b0;
    checks++;
    if (bit_valid[0] !== 1'b1 || bit_idx[0] !== 3'd2 || mux_sel[0] !== 3'd2) begin
      errors++;
      $display("FAIL t6_hold vld=%b idx=%0d sel=%0d exp 1/2/2", bit_valid[0], bit_idx[0], mux_sel[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bit_valid[0] !== 1'b0 || mux_sel[0] !== 3'd0 || mux_i[0] !== 8'h00 || in_ready[0] !== 1'b0) begin
      errors++;
      $display("FAIL t6_async_reset vld=%b sel=%0d mux_i=%h rdy=%b exp 0/0/00/0",
               bit_valid[0], mux_sel[0], mux_i[0], in_ready[0]);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bit_ready[0] = 1'b1;
    bit_ready[2] = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bit_valid[0] === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen || in_ready[2] !== 1'b1) begin
      errors++;
      $display("FAIL t6_after_release partial_bit=%b rdy2=%b exp 0/1", seen, in_ready[2]);
    end
    w = 8'h55;
    load(2, w);
    for (int i = 0; i < 8; i++) begin
      wait_valid(2, cyc);
      checks++;
      if (cyc != 1) begin
        errors++;
        $display("FAIL t6_latency bit=%0d got=%0d exp=1", i, cyc);
      end
      checks++;
      if (bit_out[2] !== w[i] || bit_idx[2] !== 3'(i) || bit_last[2] !== (i == 7) || err[2] !== 1'b0) begin
        errors++;
        $display("FAIL t6_bit i=%0d out=%b idx=%0d last=%b err=%b exp %b/%0d/%b/0",
                 i, bit_out[2], bit_idx[2], bit_last[2], err[2], w[i], i, (i == 7));
      end
      @(negedge clk);
    end
    checks++;
    if (in_ready[2] !== 1'b1) begin
      errors++;
      $display("FAIL t6_end_ready got=%b exp=1", in_ready[2]);
    end
  endtask

  initial begin
    test_reset();
    test_lsb_first();
    test_msb_first();
    test_stall();
    test_fault();
    test_abort();
    test_reset_mid_scan();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_scan_serializer.md
Name: mux_scan_serializer

Overview:
- Sequential driver/consumer stage wrapped around the eight_one 8:1 mux.
- Accepts an 8-bit word over a valid/ready handshake and holds it on the mux data inputs.
- Steps the 3-bit select through all eight channels, samples the mux output after a configurable settle time, and emits one bit per channel on a valid/ready serial stream.
- Checks every sampled mux output against the held word and flags mismatches, so the block also acts as an in-system self-check of the mux.

Parameters:
- MSB_FIRST, 0: 0 scans channel 0 to 7; 1 scans channel 7 to 0.
- SETTLE, 1: idle cycles between a select change and the sample. Legal range 0..15.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  word offered.
- in_ready  out  1  block can accept a word.
- in_data  in  8  word to serialise.
- abort  in  1  synchronous abort of the current scan.
- mux_i  out  8  held word, driven to the mux I inputs.
- mux_sel  out  3  driven to the mux Sel input.
- mux_y  in  1  returned from the mux Y output.
- bit_valid  out  1  serial bit available.
- bit_ready  in  1  downstream accepts the bit.
- bit_out  out  1  sampled channel value.
- bit_last  out  1  high with the eighth bit of a word.
- bit_idx  out  3  channel index of bit_out.
- err  out  1  sticky mismatch flag.

Behaviour:
- **Reset (rst_n low, asynchronous)**
  - State goes to IDLE.
  - mux_i=0, mux_sel=0, bit_valid=0, bit_out=0, bit_last=0, bit_idx=0, err=0.
  - Settle counter cleared.
  - in_ready=1 from the first clock edge after rst_n is released.
- **States: IDLE, SETTLE, SAMPLE, HOLD.** in_ready=1 only in IDLE; all outputs are registered.
- **IDLE**
  - Load occurs on in_valid&&in_ready.
  - On load: mux_i<=in_data; mux_sel<=start channel (0 if MSB_FIRST=0, else 7); cnt<=SETTLE; err<=0.
  - Next state is SETTLE if SETTLE>0, else SAMPLE.
- **SETTLE:** cnt decrements each cycle; moves to SAMPLE in the cycle after cnt reaches 1.
- **SAMPLE (one cycle)**
  - bit_out<=mux_y; bit_idx<=mux_sel; bit_last<=(mux_sel==end channel); bit_valid<=1.
  - If mux_y!=mux_i[mux_sel], err<=1. err stays set until the next load or reset.
  - Next state is HOLD.
- **HOLD**
  - bit_valid, bit_out, bit_idx and bit_last hold stable until bit_valid&&bit_ready.
  - On that handshake, bit_valid<=0.
    - If bit_last: go to IDLE.
    - Otherwise: mux_sel steps by +1 (MSB_FIRST=0) or -1 (MSB_FIRST=1); cnt<=SETTLE; go to SETTLE, or to SAMPLE if SETTLE=0.
- **mux_sel wrap:** never wraps inside a word; the end channel always terminates the scan.
- **Latency**
  - Load edge to first bit_valid: SETTLE+1 cycles.
  - Bit handshake to next bit_valid: SETTLE+1 cycles.
  - Minimum word time with bit_ready tied high: 8*(SETTLE+2) cycles.
  - Last handshake to in_ready=1: 1 cycle.
- **Back-to-back words:** a new word can only load in IDLE, so the earliest load is the cycle after the last handshake. mux_i is never changed mid-scan.
- **abort** (sampled every cycle, ignored in IDLE)
  - Forces IDLE next cycle: bit_valid<=0, bit_last<=0.
  - mux_i, mux_sel and err retain their values.
  - abort beats a simultaneous bit handshake: the bit is considered delivered, and no further bits follow.
- **in_valid outside IDLE** is ignored; in_data is not sampled.
- **Reset mid-scan:** all state is discarded immediately, with no partial-word output after release.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE=2'd0, SETTLE=2'd1, SAMPLE=2'd2, HOLD=2'd3;
  - channel-count constant 8 and select width 3;
  - settle-counter width 4.
- Natural sub-module: mux_scan_seq, containing the state register, settle counter and select stepper.
- The top level holds the data register, the sample/compare logic and the output registers.
- The test bench instantiates eight_one as the mux under the block.

Test Plan:
1. Reset, then load in_data=8'hA5 with MSB_FIRST=0, SETTLE=1, bit_ready=1 -> bits 1,0,1,0,0,1,0,1 with bit_idx 0..7; bit_last only on idx 7; first bit_valid 2 cycles after load; err=0; in_ready=1 one cycle after the last bit.
2. MSB_FIRST=1, in_data=8'h3C -> bits 0,0,1,1,1,1,0,0 with bit_idx 7..0; bit_last on idx 0.
3. in_data=8'hFF, bit_ready low for 5 cycles on bit 3 -> bit_valid, bit_out and bit_idx=3 stay stable for the whole stall; mux_sel is unchanged; the rest of the stream resumes correctly.
4. Insert a fault forcing mux_y=0 while in_data=8'h80, MSB_FIRST=0 -> err rises in the SAMPLE cycle of idx 7 and stays high; the next load clears it.
5. Assert abort for one cycle during SETTLE of idx 4 -> IDLE next cycle; no further bit_valid; in_ready=1; a new word 8'h01 then scans cleanly from idx 0.
6. Drop rst_n asynchronously mid-HOLD of idx 2 -> bit_valid=0 and mux_sel=0 immediately, without a clock edge; after release, in_valid with in_data=8'h55 while SETTLE=0 gives its first bit 1 cycle after load.
